// File: rtl/m6809_core_pkg.sv
// ---------------------------------------------------------------------------
// m6809_core_pkg
// Shared definitions for the 6809 core datapath blocks:
//   - addressing-mode encodings used by the operand fetch unit
//   - opfetch state enumeration
//   - 16-bit zero word used as a reset value
//   - helper telling whether an opfetch state drives a bus read
// ---------------------------------------------------------------------------
package m6809_core_pkg;

   localparam logic [1:0]  MODE_IMM  = 2'b00;
   localparam logic [1:0]  MODE_DIR  = 2'b01;
   localparam logic [1:0]  MODE_EXT  = 2'b10;

   localparam logic [15:0] WORD_ZERO = 16'h0000;

   typedef enum logic [2:0] {
      OPF_IDLE   = 3'd0,
      OPF_PTR_HI = 3'd1,
      OPF_PTR_LO = 3'd2,
      OPF_DAT_HI = 3'd3,
      OPF_DAT_LO = 3'd4,
      OPF_VALID  = 3'd5
   } opf_state_e;

   // True for every state that owns the memory bus (pointer or data byte read).
   function automatic logic is_bus_state(input opf_state_e s);
      logic r;
      case (s)
         OPF_PTR_HI, OPF_PTR_LO, OPF_DAT_HI, OPF_DAT_LO: r = 1'b1;
         default:                                        r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/m6809_core_opfetch16_if.sv
// ---------------------------------------------------------------------------
// m6809_core_opfetch16_if
// Groups the 8-bit memory read bus and the operand handshake towards the ALU.
//   mem_addr/mem_rd      read address and strobe (fetch unit -> memory)
//   mem_rdata/mem_ready  read data and completion (memory -> fetch unit)
//   operand/operand_valid assembled word (fetch unit -> ALU)
//   alu_accept           ALU consumes the operand (ALU -> fetch unit)
// master = fetch unit side, slave = memory/ALU side.
// ---------------------------------------------------------------------------
interface m6809_core_opfetch16_if;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_rdata;
   logic        mem_ready;
   logic [15:0] operand;
   logic        operand_valid;
   logic        alu_accept;

   modport master (
      output mem_addr, mem_rd, operand, operand_valid,
      input  mem_rdata, mem_ready, alu_accept
   );

   modport slave (
      input  mem_addr, mem_rd, operand, operand_valid,
      output mem_rdata, mem_ready, alu_accept
   );
endinterface

// File: rtl/m6809_core_wait_timer.sv
// ---------------------------------------------------------------------------
// m6809_core_wait_timer
// Counts consecutive stalled bus cycles and flags the cycle in which the
// WAIT_TIMEOUT-th consecutive stall is seen, so the owner can abort in that
// same cycle.
//   clk      core clock
//   reset    synchronous active-high reset
//   clear    restart the count (a read completed or the bus is idle)
//   stall    a read is pending and memory is not ready this cycle
//   timeout  this is the WAIT_TIMEOUT-th consecutive stalled cycle
// ---------------------------------------------------------------------------
module m6809_core_wait_timer #(
   parameter int unsigned WAIT_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic stall,
   output logic timeout
);

   localparam int unsigned   CW   = $clog2(WAIT_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(WAIT_TIMEOUT - 1);

   logic [CW-1:0] count_r;

   // Stall counter: clear has priority, counting stops at the last value.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {CW{1'b0}};
      end else if (clear) begin
         count_r <= {CW{1'b0}};
      end else if (stall && (count_r != LAST)) begin
         count_r <= count_r + CW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   // Combinational so the owner can abort on the timing-out cycle itself.
   assign timeout = stall && (count_r == LAST);

endmodule

// File: rtl/m6809_core_opfetch16.sv
// ---------------------------------------------------------------------------
// m6809_core_opfetch16
// 16-bit operand fetch unit feeding the ALU RHS operand. Reads a big-endian
// word over the 8-bit bus in immediate, direct or extended mode, computes
// the PC after the operand bytes and holds the word until the ALU accepts.
//   clk, reset      core clock, synchronous active-high reset
//   start, mode     begin fetch (sampled in IDLE only), addressing mode
//   pc_in, dp_in    first operand byte address and direct page
//   bus (master)    memory read bus + operand/operand_valid/alu_accept
//   pc_out          advanced PC, valid with operand_valid
//   busy            high in every state except IDLE
//   err             one-cycle pulse: illegal mode or bus wait timeout
// Optional (macro M6809_OPFETCH_CYCLE_COUNT_EN):
//   fetch_cycles    cycles spent in bus states for the last fetch, sat. 31,
//                   plus a checker on legal state encoding.
// All outputs are registered; bus address/strobe are computed from the next
// state so they line up with the state that performs the read.
// ---------------------------------------------------------------------------
module m6809_core_opfetch16
   import m6809_core_pkg::*;
#(
   parameter int unsigned WAIT_TIMEOUT = 15
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [1:0]                   mode,
   input  logic [15:0]                  pc_in,
   input  logic [7:0]                   dp_in,
   m6809_core_opfetch16_if.master       bus,
   output logic [15:0]                  pc_out,
   output logic                         busy,
   output logic                         err
`ifdef M6809_OPFETCH_CYCLE_COUNT_EN
   ,
   output logic [4:0]                   fetch_cycles
`endif
);

   opf_state_e  state_r, state_nxt_s;
   logic [15:0] ea_r, ea_nxt_s;
   logic [7:0]  hi_r, hi_nxt_s;
   logic [15:0] pc_r, pc_nxt_s;
   logic [7:0]  dp_r, dp_nxt_s;
   logic [1:0]  mode_r, mode_nxt_s;
   logic [15:0] mem_addr_r, addr_nxt_s;
   logic        mem_rd_r;
   logic [15:0] operand_r, operand_nxt_s;
   logic        operand_valid_r;
   logic [15:0] pc_out_r, pc_out_nxt_s;
   logic        busy_r;
   logic        err_r, err_nxt_s;

   logic        stall_s, done_s, clear_s, timeout_s;

   assign stall_s = mem_rd_r & ~bus.mem_ready;
   assign done_s  = mem_rd_r &  bus.mem_ready;
   assign clear_s = ~stall_s;

   m6809_core_wait_timer #(
      .WAIT_TIMEOUT (WAIT_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear_s),
      .stall   (stall_s),
      .timeout (timeout_s)
   );

   // Next-state and next-register values; a timeout in any bus state aborts.
   always_comb begin
      state_nxt_s   = state_r;
      ea_nxt_s      = ea_r;
      hi_nxt_s      = hi_r;
      pc_nxt_s      = pc_r;
      dp_nxt_s      = dp_r;
      mode_nxt_s    = mode_r;
      addr_nxt_s    = mem_addr_r;
      operand_nxt_s = operand_r;
      pc_out_nxt_s  = pc_out_r;
      err_nxt_s     = 1'b0;

      case (state_r)
         OPF_IDLE: begin
            if (start) begin
               case (mode)
                  MODE_IMM: begin
                     pc_nxt_s    = pc_in;
                     mode_nxt_s  = mode;
                     ea_nxt_s    = pc_in;
                     addr_nxt_s  = pc_in;
                     state_nxt_s = OPF_DAT_HI;
                  end
                  MODE_DIR: begin
                     pc_nxt_s    = pc_in;
                     dp_nxt_s    = dp_in;
                     mode_nxt_s  = mode;
                     addr_nxt_s  = pc_in;
                     state_nxt_s = OPF_PTR_LO;
                  end
                  MODE_EXT: begin
                     pc_nxt_s    = pc_in;
                     mode_nxt_s  = mode;
                     addr_nxt_s  = pc_in;
                     state_nxt_s = OPF_PTR_HI;
                  end
                  default: begin
                     err_nxt_s   = 1'b1;
                     state_nxt_s = OPF_IDLE;
                  end
               endcase
            end else begin
               state_nxt_s = OPF_IDLE;
            end
         end

         OPF_PTR_HI: begin
            if (timeout_s) begin
               err_nxt_s   = 1'b1;
               state_nxt_s = OPF_IDLE;
            end else if (done_s) begin
               ea_nxt_s[15:8] = bus.mem_rdata;
               addr_nxt_s     = pc_r + 16'd1;
               state_nxt_s    = OPF_PTR_LO;
            end else begin
               state_nxt_s = OPF_PTR_HI;
            end
         end

         OPF_PTR_LO: begin
            if (timeout_s) begin
               err_nxt_s   = 1'b1;
               state_nxt_s = OPF_IDLE;
            end else if (done_s) begin
               if (mode_r == MODE_DIR) begin
                  ea_nxt_s     = {dp_r, bus.mem_rdata};
                  addr_nxt_s   = {dp_r, bus.mem_rdata};
                  pc_out_nxt_s = pc_r + 16'd1;
               end else begin
                  ea_nxt_s     = {ea_r[15:8], bus.mem_rdata};
                  addr_nxt_s   = {ea_r[15:8], bus.mem_rdata};
                  pc_out_nxt_s = pc_r + 16'd2;
               end
               state_nxt_s = OPF_DAT_HI;
            end else begin
               state_nxt_s = OPF_PTR_LO;
            end
         end

         OPF_DAT_HI: begin
            if (timeout_s) begin
               err_nxt_s   = 1'b1;
               state_nxt_s = OPF_IDLE;
            end else if (done_s) begin
               hi_nxt_s    = bus.mem_rdata;
               // 16-bit wrap: an operand at FFFF takes its low byte from 0000.
               addr_nxt_s  = ea_r + 16'd1;
               state_nxt_s = OPF_DAT_LO;
            end else begin
               state_nxt_s = OPF_DAT_HI;
            end
         end

         OPF_DAT_LO: begin
            if (timeout_s) begin
               err_nxt_s   = 1'b1;
               state_nxt_s = OPF_IDLE;
            end else if (done_s) begin
               // The high byte is held aside so an abort leaves operand untouched.
               operand_nxt_s = {hi_r, bus.mem_rdata};
               if (mode_r == MODE_IMM) begin
                  pc_out_nxt_s = pc_r + 16'd2;
               end else begin
                  pc_out_nxt_s = pc_out_r;
               end
               state_nxt_s = OPF_VALID;
            end else begin
               state_nxt_s = OPF_DAT_LO;
            end
         end

         OPF_VALID: begin
            if (bus.alu_accept) begin
               state_nxt_s = OPF_IDLE;
            end else begin
               state_nxt_s = OPF_VALID;
            end
         end

         default: begin
            state_nxt_s = OPF_IDLE;
         end
      endcase
   end

   // State and registered outputs; strobes are derived from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r         <= OPF_IDLE;
         ea_r            <= WORD_ZERO;
         hi_r            <= 8'h00;
         pc_r            <= WORD_ZERO;
         dp_r            <= 8'h00;
         mode_r          <= MODE_IMM;
         mem_addr_r      <= WORD_ZERO;
         mem_rd_r        <= 1'b0;
         operand_r       <= WORD_ZERO;
         operand_valid_r <= 1'b0;
         pc_out_r        <= WORD_ZERO;
         busy_r          <= 1'b0;
         err_r           <= 1'b0;
      end else begin
         state_r         <= state_nxt_s;
         ea_r            <= ea_nxt_s;
         hi_r            <= hi_nxt_s;
         pc_r            <= pc_nxt_s;
         dp_r            <= dp_nxt_s;
         mode_r          <= mode_nxt_s;
         mem_addr_r      <= addr_nxt_s;
         mem_rd_r        <= is_bus_state(state_nxt_s);
         operand_r       <= operand_nxt_s;
         operand_valid_r <= (state_nxt_s == OPF_VALID);
         pc_out_r        <= pc_out_nxt_s;
         busy_r          <= (state_nxt_s != OPF_IDLE);
         err_r           <= err_nxt_s;
      end
   end

   assign bus.mem_addr      = mem_addr_r;
   assign bus.mem_rd        = mem_rd_r;
   assign bus.operand       = operand_r;
   assign bus.operand_valid = operand_valid_r;
   assign pc_out            = pc_out_r;
   assign busy              = busy_r;
   assign err               = err_r;

`ifdef M6809_OPFETCH_CYCLE_COUNT_EN
   logic [4:0] cyc_r;
   logic [4:0] fetch_cycles_r;
   logic [4:0] cyc_inc_s;

   assign cyc_inc_s = (cyc_r == 5'd31) ? 5'd31 : (cyc_r + 5'd1);

   // Counts bus-state cycles (waits included) and publishes on entry to VALID.
   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_r          <= 5'd0;
         fetch_cycles_r <= 5'd0;
      end else begin
         if (state_r == OPF_IDLE) begin
            cyc_r <= 5'd0;
         end else if (is_bus_state(state_r)) begin
            cyc_r <= cyc_inc_s;
         end else begin
            cyc_r <= cyc_r;
         end
         if (is_bus_state(state_r) && (state_nxt_s == OPF_VALID)) begin
            fetch_cycles_r <= cyc_inc_s;
         end else begin
            fetch_cycles_r <= fetch_cycles_r;
         end
      end
   end

   assign fetch_cycles = fetch_cycles_r;

   m6809_core_opfetch16_chk u_chk (
      .clk   (clk),
      .reset (reset),
      .state (state_r)
   );
`endif

endmodule

`ifdef M6809_OPFETCH_CYCLE_COUNT_EN
// ---------------------------------------------------------------------------
// m6809_core_opfetch16_chk
// Checker: the opfetch state register must always decode to exactly one of
// the six legal states.
// ---------------------------------------------------------------------------
module m6809_core_opfetch16_chk
   import m6809_core_pkg::*;
(
   input logic       clk,
   input logic       reset,
   input opf_state_e state
);

   logic [5:0] dec_s;

   // One-hot decode of the state; an unlisted encoding gives all zeros.
   always_comb begin
      dec_s = 6'b000000;
      case (state)
         OPF_IDLE:   dec_s = 6'b000001;
         OPF_PTR_HI: dec_s = 6'b000010;
         OPF_PTR_LO: dec_s = 6'b000100;
         OPF_DAT_HI: dec_s = 6'b001000;
         OPF_DAT_LO: dec_s = 6'b010000;
         OPF_VALID:  dec_s = 6'b100000;
         default:    dec_s = 6'b000000;
      endcase
   end

   state_legal: assert property (@(posedge clk) disable iff (reset) $onehot(dec_s));

endmodule
`endif

// File: tb/tb_m6809_core_opfetch16.sv
// ---------------------------------------------------------------------------
// tb_m6809_core_opfetch16
// Directed bench for the 16-bit operand fetch unit. A flat 64 KiB memory
// answers reads combinationally; mem_ready is driven per step. Inputs change
// and outputs are checked on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_m6809_core_opfetch16;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  mode;
   logic [15:0] pc_in;
   logic [7:0]  dp_in;
   logic [15:0] pc_out;
   logic        busy;
   logic        err;
`ifdef M6809_OPFETCH_CYCLE_COUNT_EN
   logic [4:0]  fetch_cycles;
`endif

   logic [7:0]  mem [0:65535];
   int          n_assert = 0;
   int          n_fail   = 0;

   m6809_core_opfetch16_if bus ();

   assign bus.mem_rdata = mem[bus.mem_addr];

   m6809_core_opfetch16 #(
      .WAIT_TIMEOUT (15)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .mode         (mode),
      .pc_in        (pc_in),
      .dp_in        (dp_in),
      .bus          (bus.master),
      .pc_out       (pc_out),
      .busy         (busy),
      .err          (err)
`ifdef M6809_OPFETCH_CYCLE_COUNT_EN
      ,
      .fetch_cycles (fetch_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Presents start for one edge; returns at the falling edge of the first
   // cycle after the start-accept cycle.
   task automatic start_fetch(input logic [1:0] m, input logic [15:0] pc, input logic [7:0] dp);
      start = 1'b1;
      mode  = m;
      pc_in = pc;
      dp_in = dp;
      tick();
      start = 1'b0;
   endtask

   task automatic accept();
      bus.alu_accept = 1'b1;
      tick();
      bus.alu_accept = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      reset          = 1'b1;
      start          = 1'b0;
      mode           = 2'b00;
      pc_in          = 16'h0000;
      dp_in          = 8'h00;
      bus.mem_ready  = 1'b1;
      bus.alu_accept = 1'b0;
      repeat (2) tick();

      // Reset values
      chk16("rst_mem_addr", bus.mem_addr, 16'h0000);
      chk1 ("rst_mem_rd", bus.mem_rd, 1'b0);
      chk16("rst_operand", bus.operand, 16'h0000);
      chk1 ("rst_valid", bus.operand_valid, 1'b0);
      chk16("rst_pc_out", pc_out, 16'h0000);
      chk1 ("rst_busy", busy, 1'b0);
      chk1 ("rst_err", err, 1'b0);
      reset = 1'b0;
      tick();

      // Immediate, zero waits
      mem[16'h1000] = 8'h12;
      mem[16'h1001] = 8'h34;
      start_fetch(2'b00, 16'h1000, 8'h00);
      chk1 ("imm_busy", busy, 1'b1);
      chk1 ("imm_rd_hi", bus.mem_rd, 1'b1);
      chk16("imm_addr_hi", bus.mem_addr, 16'h1000);
      tick();
      chk16("imm_addr_lo", bus.mem_addr, 16'h1001);
      chk1 ("imm_valid_early", bus.operand_valid, 1'b0);
      tick();
      chk1 ("imm_valid", bus.operand_valid, 1'b1);
      chk16("imm_operand", bus.operand, 16'h1234);
      chk16("imm_pc_out", pc_out, 16'h1002);
      chk1 ("imm_rd_valid", bus.mem_rd, 1'b0);
      chk1 ("imm_err", err, 1'b0);
      repeat (2) tick();
      chk1 ("imm_hold_valid", bus.operand_valid, 1'b1);
      chk16("imm_hold_operand", bus.operand, 16'h1234);
      accept();
      chk1 ("imm_drop_valid", bus.operand_valid, 1'b0);
      chk1 ("imm_idle_busy", busy, 1'b0);

      // Direct with page carry on the low-byte read
      mem[16'h2000] = 8'hFF;
      mem[16'h12FF] = 8'hAB;
      mem[16'h1300] = 8'hCD;
      start_fetch(2'b01, 16'h2000, 8'h12);
      chk16("dir_addr_ptr", bus.mem_addr, 16'h2000);
      tick();
      chk16("dir_addr_hi", bus.mem_addr, 16'h12FF);
      tick();
      chk16("dir_addr_lo", bus.mem_addr, 16'h1300);
      tick();
      chk1 ("dir_valid", bus.operand_valid, 1'b1);
      chk16("dir_operand", bus.operand, 16'hABCD);
      chk16("dir_pc_out", pc_out, 16'h2001);
      accept();

      // Extended with address wrap at FFFF
      mem[16'h3000] = 8'hFF;
      mem[16'h3001] = 8'hFF;
      mem[16'hFFFF] = 8'h5A;
      mem[16'h0000] = 8'hA5;
      start_fetch(2'b10, 16'h3000, 8'h00);
      chk16("ext_addr_ptrhi", bus.mem_addr, 16'h3000);
      tick();
      chk16("ext_addr_ptrlo", bus.mem_addr, 16'h3001);
      tick();
      chk16("ext_addr_hi", bus.mem_addr, 16'hFFFF);
      tick();
      chk16("ext_addr_wrap", bus.mem_addr, 16'h0000);
      chk1 ("ext_valid_early", bus.operand_valid, 1'b0);
      tick();
      chk1 ("ext_valid", bus.operand_valid, 1'b1);
      chk16("ext_operand", bus.operand, 16'h5AA5);
      chk16("ext_pc_out", pc_out, 16'h3002);
`ifdef M6809_OPFETCH_CYCLE_COUNT_EN
      chk16("ext_fetch_cycles", {11'd0, fetch_cycles}, 16'd4);
`endif
      // start together with alu_accept must be ignored
      start = 1'b1;
      mode  = 2'b00;
      pc_in = 16'h1000;
      accept();
      start = 1'b0;
      chk1 ("acc_start_busy", busy, 1'b0);
      chk1 ("acc_start_valid", bus.operand_valid, 1'b0);
      tick();
      chk1 ("acc_start_still_idle", busy, 1'b0);
      chk1 ("acc_start_no_rd", bus.mem_rd, 1'b0);

      // Immediate with 3 wait cycles on the high byte
      mem[16'h4000] = 8'h9A;
      mem[16'h4001] = 8'hBC;
      start_fetch(2'b00, 16'h4000, 8'h00);
      bus.mem_ready = 1'b0;
      tick();
      chk16("wait_addr_stable1", bus.mem_addr, 16'h4000);
      chk1 ("wait_rd1", bus.mem_rd, 1'b1);
      repeat (2) tick();
      chk16("wait_addr_stable3", bus.mem_addr, 16'h4000);
      chk1 ("wait_valid_early", bus.operand_valid, 1'b0);
      bus.mem_ready = 1'b1;
      tick();
      chk16("wait_addr_lo", bus.mem_addr, 16'h4001);
      tick();
      chk1 ("wait_valid", bus.operand_valid, 1'b1);
      chk16("wait_operand", bus.operand, 16'h9ABC);
      chk16("wait_pc_out", pc_out, 16'h4002);
      accept();

      // 15 consecutive wait cycles abort the fetch
      start_fetch(2'b00, 16'h5000, 8'h00);
      bus.mem_ready = 1'b0;
      repeat (14) tick();
      chk1 ("tmo_busy_before", busy, 1'b1);
      chk1 ("tmo_err_before", err, 1'b0);
      tick();
      chk1 ("tmo_err", err, 1'b1);
      chk1 ("tmo_busy", busy, 1'b0);
      chk1 ("tmo_rd", bus.mem_rd, 1'b0);
      chk1 ("tmo_valid", bus.operand_valid, 1'b0);
      chk16("tmo_operand_kept", bus.operand, 16'h9ABC);
      bus.mem_ready = 1'b1;
      tick();
      chk1 ("tmo_err_pulse", err, 1'b0);

      // Illegal mode
      start_fetch(2'b11, 16'h6000, 8'h00);
      chk1 ("ill_err", err, 1'b1);
      chk1 ("ill_busy", busy, 1'b0);
      chk1 ("ill_rd", bus.mem_rd, 1'b0);
      tick();
      chk1 ("ill_err_pulse", err, 1'b0);

      // start while busy in DAT_HI is ignored
      mem[16'h6000] = 8'h11;
      mem[16'h6001] = 8'h22;
      start_fetch(2'b00, 16'h6000, 8'h00);
      start = 1'b1;
      mode  = 2'b10;
      pc_in = 16'h7000;
      tick();
      start = 1'b0;
      chk16("busy_start_addr", bus.mem_addr, 16'h6001);
      tick();
      chk1 ("busy_start_valid", bus.operand_valid, 1'b1);
      chk16("busy_start_operand", bus.operand, 16'h1122);
      chk16("busy_start_pc", pc_out, 16'h6002);
      chk1 ("busy_start_err", err, 1'b0);
      accept();

      // Reset while in DAT_LO
      mem[16'h8000] = 8'h77;
      mem[16'h8001] = 8'h88;
      start_fetch(2'b00, 16'h8000, 8'h00);
      tick();
      chk16("rdl_addr", bus.mem_addr, 16'h8001);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk1 ("rdl_busy", busy, 1'b0);
      chk1 ("rdl_valid", bus.operand_valid, 1'b0);
      chk16("rdl_operand", bus.operand, 16'h0000);
      chk1 ("rdl_rd", bus.mem_rd, 1'b0);
      chk16("rdl_pc_out", pc_out, 16'h0000);
      tick();
      chk1 ("rdl_valid_after", bus.operand_valid, 1'b0);

`ifdef M6809_OPFETCH_CYCLE_COUNT_EN
      // Extended fetch with 2 wait cycles on the first pointer byte
      start_fetch(2'b10, 16'h3000, 8'h00);
      bus.mem_ready = 1'b0;
      repeat (2) tick();
      bus.mem_ready = 1'b1;
      repeat (4) tick();
      chk1 ("cnt_valid", bus.operand_valid, 1'b1);
      chk16("cnt_operand", bus.operand, 16'h5AA5);
      chk16("cnt_fetch_cycles", {11'd0, fetch_cycles}, 16'd6);
      accept();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/m6809_core_opfetch16.md
Name: m6809_core_opfetch16

Overview:
- Sequential 16-bit operand fetch unit for the 6809 core.
- Sits directly upstream of the 16-bit ALU and drives its RHS operand (alu_in_b) for ADDD/SUBD/CMPx/LDx.
- Reads big-endian operands over the 8-bit memory bus in immediate, direct and extended modes, then computes the advanced PC.
- Holds the assembled word until the ALU stage accepts it.

Parameters:
- WAIT_TIMEOUT, default 15: maximum consecutive cycles a bus read may stall (mem_ready low) before the fetch aborts with err.

Ports:
- clk  input  1  core clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin fetch; sampled only in IDLE
- mode  input  2  00 immediate, 01 direct, 10 extended, 11 illegal
- pc_in  input  16  address of first operand byte (byte after opcode), sampled with start
- dp_in  input  8  direct-page register, sampled with start
- mem_addr  output  16  bus read address
- mem_rd  output  1  bus read strobe
- mem_rdata  input  8  read data, valid when mem_rd & mem_ready
- mem_ready  input  1  read completes this cycle when high
- operand  output  16  assembled operand {hi,lo} to the ALU
- operand_valid  output  1  operand and pc_out valid; held until accepted
- alu_accept  input  1  ALU consumes operand this cycle
- pc_out  output  16  PC after operand bytes (pc_in+2 for imm/ext, pc_in+1 for direct)
- busy  output  1  high in every state except IDLE
- err  output  1  one-cycle pulse on illegal mode or bus timeout

Behaviour:
- Reset values: mem_addr=0000, mem_rd=0, operand=0000, operand_valid=0, pc_out=0000, busy=0, err=0; state=IDLE.
- States: IDLE, PTR_HI, PTR_LO, DAT_HI, DAT_LO, VALID.
- IDLE, start=1:
  - mode 00: go to DAT_HI with ea=pc_in.
  - mode 01: go to PTR_LO.
  - mode 10: go to PTR_HI.
  - mode 11: err=1 for one cycle, stay in IDLE.
- IDLE, start=0: stay.
- PTR_HI (extended only): read pc; on ready latch ea[15:8]; go to PTR_LO.
- PTR_LO:
  - Direct: read pc; on ready ea={dp,rdata}; pc_out=pc_in+1.
  - Extended: read pc_in+1; on ready ea[7:0]=rdata; pc_out=pc_in+2.
  - Both then go to DAT_HI.
- DAT_HI: read ea; on ready latch operand[15:8]; go to DAT_LO.
- DAT_LO: read ea+1; on ready latch operand[7:0]; go to VALID.
  - Immediate mode sets pc_out=pc_in+2 here.
- VALID: operand_valid=1. On alu_accept go to IDLE; operand_valid drops the next cycle.
- start may arrive in the same cycle as alu_accept, but is ignored; restart needs a cycle in IDLE.
- Address arithmetic is full 16-bit and wraps:
  - ea=FFFF reads the low byte at 0000.
  - Direct page carries: dp=12, offset=FF gives reads at 12FF then 1300.
- Bus timing:
  - In PTR_*/DAT_* states, mem_rd=1 and mem_addr is registered and stable until ready.
  - One bus cycle per clock with zero wait states.
  - Latency from start to operand_valid: immediate 2+1, direct 3+1, extended 4+1 cycles (fetch states + VALID), plus wait cycles.
- Wait states:
  - A wait counter resets at each completed read.
  - If mem_ready stays low for WAIT_TIMEOUT consecutive cycles, pulse err, force mem_rd=0, go to IDLE, leave operand unchanged.
- start while busy: ignored, no error.
- reset in any state: next cycle is IDLE with all outputs at reset values; a partially assembled operand is discarded.
- err and operand_valid are never high together.

Optional Feature:
- Macro: M6809_OPFETCH_CYCLE_COUNT_EN.
- Defined:
  - Adds output fetch_cycles[4:0]: clocks from the start-accept cycle to the first VALID cycle, including waits.
  - Saturates at 31; updated on entry to VALID; reset to 0.
  - Adds a clocked assertion that the state is one-hot-decoded legal.
- Undefined: no port, no counter, no assertion; all other behaviour identical.

Decomposition:
- Shared package m6809_core_pkg holds:
  - Mode encodings: MODE_IMM=2'b00, MODE_DIR=2'b01, MODE_EXT=2'b10.
  - Opfetch state enum.
  - Reset constant for a 16-bit zero word.
- Sub-module m6809_core_wait_timer (parameter WAIT_TIMEOUT):
  - Inputs: clk, reset, clear, stall.
  - Output: timeout.
  - Reused later by the 16-bit store/writeback sequencer.

Test Plan:
- Immediate, pc_in=1000, memory 1000=12, 1001=34, zero waits: operand=1234 and pc_out=1002 in cycle 3; held until alu_accept, then operand_valid=0 next cycle.
- Direct, dp=12, pc_in=2000, mem 2000=FF, 12FF=AB, 1300=CD: reads at 2000, 12FF, 1300; operand=ABCD, pc_out=2001.
- Extended, pc_in=3000, mem 3000=FF, 3001=FF, FFFF=5A, 0000=A5: operand=5AA5 (wrap), pc_out=3002, 5 cycles to valid.
- Waits: immediate with mem_ready low for 3 cycles on the hi byte: mem_addr stable at the hi address during the stall, valid 3 cycles later; with mem_ready low for 15 cycles: err pulse, busy=0, mem_rd=0.
- Misuse: mode=11 gives a one-cycle err and no bus read; start during DAT_HI is ignored; reset asserted in DAT_LO gives IDLE, operand=0000, operand_valid=0 the next cycle.
- With M6809_OPFETCH_CYCLE_COUNT_EN: extended fetch with 2 wait cycles gives fetch_cycles=6.
